// File: rtl/debug_mailbox_responder.sv
// Responder end of the req/wr/ack word mailbox, bridging debug clients to a host word stream via RX/TX FIFOs.
// Optional read/write completion counters are built when DEBUG_MAILBOX_STATS_EN is defined.
module debug_mailbox_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  output logic                  ack,
  input  logic                  host_rx_valid,
  input  logic [WIDTH-1:0]      host_rx_data,
  output logic                  host_rx_ready,
  output logic                  host_tx_valid,
  output logic [WIDTH-1:0]      host_tx_data,
  input  logic                  host_tx_ready,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [15:0]           stat_rd,
  output logic [15:0]           stat_wr,
  output logic [1:0]            fsm_state
);

  // Handshake: a host word moves when valid & ready are both high at a clock edge;
  // a client transaction is taken when req is sampled high in IDLE and completes with a one-cycle ack.

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]    rx_mem [DEPTH];
  logic [WIDTH-1:0]    tx_mem [DEPTH];
  logic [DEPTH_LOG2:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic                rx_empty, rx_full, tx_empty, tx_full;
  logic                rx_push, rx_pop, tx_push, tx_pop;

  assign rx_level = rx_wptr - rx_rptr;
  assign tx_level = tx_wptr - tx_rptr;
  assign rx_empty = (rx_wptr == rx_rptr);
  assign tx_empty = (tx_wptr == tx_rptr);
  assign rx_full  = (rx_level == FULL_LEVEL);
  assign tx_full  = (tx_level == FULL_LEVEL);

  assign host_rx_ready = ~rx_full;
  assign rx_push       = host_rx_valid & ~rx_full;
  assign host_tx_valid = ~tx_empty;
  assign host_tx_data  = tx_mem[tx_rptr[DEPTH_LOG2-1:0]];
  assign tx_pop        = host_tx_ready & ~tx_empty;

  assign ack       = (state == ST_ACK);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && !wr && !rx_empty) begin
          rx_pop     = 1'b1;
          state_next = ST_ACK;
        end else if (req && wr && (!tx_full || tx_pop)) begin
          // A host pop in the same cycle frees the slot, so a full TX can still take the word.
          tx_push    = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_GAP;
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      q       <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      state <= state_next;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop) begin
        q       <= rx_mem[rx_rptr[DEPTH_LOG2-1:0]];
        rx_rptr <= rx_rptr + 1'b1;
      end
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // Storage arrays carry no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (!reset && rx_push) rx_mem[rx_wptr[DEPTH_LOG2-1:0]] <= host_rx_data;
    if (!reset && tx_push) tx_mem[tx_wptr[DEPTH_LOG2-1:0]] <= d;
  end

`ifdef DEBUG_MAILBOX_STATS_EN
  logic txn_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      txn_wr  <= 1'b0;
      stat_rd <= 16'h0;
      stat_wr <= 16'h0;
    end else begin
      if (state == ST_IDLE && state_next == ST_ACK) txn_wr <= wr;
      if (state == ST_ACK) begin
        if (txn_wr) stat_wr <= stat_wr + 16'h1;
        else        stat_rd <= stat_rd + 16'h1;
      end
    end
  end
`else
  assign stat_rd = 16'h0;
  assign stat_wr = 16'h0;
`endif

endmodule

// File: tb/tb_debug_mailbox_responder.sv
// Bench for debug_mailbox_responder: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the mailbox and its two FIFOs.
module tb_debug_mailbox_responder;

  localparam int DL    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, wr;
  logic [W-1:0]  d, q;
  logic          ack;
  logic          host_rx_valid, host_rx_ready;
  logic [W-1:0]  host_rx_data, host_tx_data;
  logic          host_tx_valid, host_tx_ready;
  logic [DL:0]   rx_level, tx_level;
  logic [15:0]   stat_rd, stat_wr;
  logic [1:0]    fsm_state;

  debug_mailbox_responder #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .d(d), .q(q), .ack(ack),
    .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
    .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
    .rx_level(rx_level), .tx_level(tx_level), .stat_rd(stat_rd), .stat_wr(stat_wr),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as queues, transaction phase 0=idle 1=ack cycle 2=gap.
  logic [W-1:0] m_rx[$];
  logic [W-1:0] m_tx[$];
  int           m_phase = 0;
  logic [W-1:0] m_q = '0;
  logic         m_wr = 1'b0;
  logic [15:0]  m_srd = 16'h0;
  logic [15:0]  m_swr = 16'h0;

`ifdef DEBUG_MAILBOX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ack", W'(ack), W'(m_phase == 1));
    check("q", q, m_q);
    check("rx_level", W'(rx_level), W'(m_rx.size()));
    check("tx_level", W'(tx_level), W'(m_tx.size()));
    check("host_rx_ready", W'(host_rx_ready), W'(m_rx.size() < DEPTH));
    check("host_tx_valid", W'(host_tx_valid), W'(m_tx.size() > 0));
    if (m_tx.size() > 0) check("host_tx_data", host_tx_data, m_tx[0]);
    check("stat_rd", W'(stat_rd), W'(m_srd));
    check("stat_wr", W'(stat_wr), W'(m_swr));
  endtask

  // Advance one clock: model consumes the pre-edge inputs, DUT is sampled 1 time unit after the edge.
  task automatic step();
    bit rpush, tpop, start_rd, start_wr;
    logic [W-1:0] rdata, wdata;
    rpush    = host_rx_valid && (m_rx.size() < DEPTH);
    tpop     = host_tx_ready && (m_tx.size() > 0);
    start_rd = (m_phase == 0) && req && !wr && (m_rx.size() > 0);
    start_wr = (m_phase == 0) && req && wr && ((m_tx.size() < DEPTH) || tpop);
    rdata    = host_rx_data;
    wdata    = d;
    @(posedge clk);
    if (reset) begin
      m_rx.delete();
      m_tx.delete();
      m_phase = 0;
      m_q     = '0;
      m_wr    = 1'b0;
      m_srd   = 16'h0;
      m_swr   = 16'h0;
    end else begin
      if (m_phase == 1 && STATS) begin
        if (m_wr) m_swr = m_swr + 16'h1;
        else      m_srd = m_srd + 16'h1;
      end
      if (tpop) void'(m_tx.pop_front());
      if (start_wr) m_tx.push_back(wdata);
      if (start_rd) m_q = m_rx.pop_front();
      if (rpush) m_rx.push_back(rdata);
      if (start_rd || start_wr) begin
        m_wr    = start_wr;
        m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else m_phase = 0;
    end
    #1;
    check_all();
  endtask

  // Client transaction: hold req until ack (bounded), then drop it and let the gap pass.
  task automatic client_txn(input bit w, input logic [W-1:0] data);
    bit got;
    got = 1'b0;
    req = 1'b1;
    wr  = w;
    d   = data;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      got = ack;
    end
    check("txn_ack_seen", W'(got), W'(1));
    req = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    bit got;
    reset = 1'b1; req = 1'b0; wr = 1'b0; d = '0;
    host_rx_valid = 1'b0; host_rx_data = '0; host_tx_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_ack", W'(ack), W'(0));
    check("rst_q", q, '0);
    check("rst_rx_ready", W'(host_rx_ready), W'(1));
    check("rst_tx_valid", W'(host_tx_valid), W'(0));

    // 1: host push then client read, ack one cycle after req
    host_rx_valid = 1'b1; host_rx_data = 32'h00FF8040;
    step();
    host_rx_valid = 1'b0;
    check("t1_rx_level1", W'(rx_level), W'(1));
    req = 1'b1; wr = 1'b0;
    step();
    check("t1_ack", W'(ack), W'(1));
    check("t1_q", q, 32'h00FF8040);
    check("t1_rx_level0", W'(rx_level), W'(0));
    req = 1'b0;
    step();
    check("t1_ack_pulse", W'(ack), W'(0));
    step();

    // 2: read stalls on empty RX, completes two cycles after the host word arrives
    req = 1'b1; wr = 1'b0;
    repeat (20) step();
    check("t2_stall_ack", W'(ack), W'(0));
    host_rx_valid = 1'b1; host_rx_data = 32'hFD000000;
    step();
    host_rx_valid = 1'b0;
    check("t2_no_early_ack", W'(ack), W'(0));
    step();
    check("t2_ack", W'(ack), W'(1));
    check("t2_q", q, 32'hFD000000);
    req = 1'b0;
    step();
    step();

    // 3: fill TX with 16 writes, 17th stalls until one host pop
    host_tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) client_txn(1'b1, W'(i));
    check("t3_tx_full", W'(tx_level), W'(DEPTH));
    check("t3_rx_ready", W'(host_rx_ready), W'(1));
    req = 1'b1; wr = 1'b1; d = 32'd16;
    repeat (5) step();
    check("t3_stall_ack", W'(ack), W'(0));
    check("t3_head", host_tx_data, 32'd0);
    host_tx_ready = 1'b1;
    step();
    host_tx_ready = 1'b0;
    got = ack;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      got = ack;
    end
    check("t3_17th_ack", W'(got), W'(1));
    req = 1'b0;
    step();
    step();
    check("t3_tx_level", W'(tx_level), W'(DEPTH));
    host_tx_ready = 1'b1;
    repeat (DEPTH + 2) step();
    host_tx_ready = 1'b0;
    check("t3_drained", W'(tx_level), W'(0));

    // 4: random concurrent host and client traffic
    for (int c = 0; c < 100; c++) begin
      req           = 1'($urandom_range(0, 1));
      wr            = 1'($urandom_range(0, 1));
      d             = $urandom;
      host_rx_valid = 1'($urandom_range(0, 1));
      host_rx_data  = $urandom;
      host_tx_ready = 1'($urandom_range(0, 1));
      step();
    end
    req = 1'b0; host_rx_valid = 1'b0; host_tx_ready = 1'b1;
    repeat (DEPTH + 3) step();
    host_tx_ready = 1'b0;

    // 5: reset during the ack cycle of a write
    req = 1'b1; wr = 1'b1; d = $urandom;
    step();
    check("t5_ack_before_reset", W'(ack), W'(1));
    reset = 1'b1; req = 1'b0;
    step();
    check("t5_ack_suppressed", W'(ack), W'(0));
    check("t5_tx_flushed", W'(tx_level), W'(0));
    reset = 1'b0;
    step();
    step();
    req = 1'b1; wr = 1'b1; d = 32'hA5A5_0001;
    step();
    check("t5_new_req_ack", W'(ack), W'(1));
    req = 1'b0;
    step();
    step();

    // 6: completion counters over 3 reads and 5 writes
    do_reset();
    for (int i = 0; i < 3; i++) begin
      host_rx_valid = 1'b1; host_rx_data = $urandom;
      step();
    end
    host_rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) client_txn(1'b0, '0);
    for (int i = 0; i < 5; i++) client_txn(1'b1, $urandom);
    check("t6_stat_rd", W'(stat_rd), STATS ? W'(3) : W'(0));
    check("t6_stat_wr", W'(stat_wr), STATS ? W'(5) : W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
